sdp_host: RTL and testbench

Bus-side initiator for the simple dual-port (SDP) peripheral access port. It accepts single read/write requests on a valid/ready channel, decodes a peripheral select from the upper address bits, and drives one-hot `we`/`re` strobes plus shared `wa`/`wd`/`ra` into a bank of SDP peripherals such as GPIO and timers. It captures each peripheral's one-cycle-latency `rd` and returns a registered response on a valid/ready channel. It sits between the core's uncached I/O path and the peripheral bank, and has at most one transaction outstanding.

---
 rtl/sdp_host.sv | 151 +++++++++++++++
 tb/tb_sdp_host.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_host.sv
// sdp_host: bus-side initiator for a bank of simple dual-port peripherals.
//
// It accepts one read or write request at a time and decodes a peripheral
// select from the upper address bits. It then pulses a one-hot we/re strobe
// for a single cycle and returns a registered response. Only one transaction
// can be outstanding.
//
// State table
//   state   | meaning
//   IDLE    | req_ready=1, waiting for a request handshake
//   ISSUE   | one-cycle strobe to the selected peripheral (none on error)
//   WAIT    | peripheral drives rd this cycle; captured at end of cycle
//   RESP    | rsp_valid=1 until rsp_ready
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request channel
//   req_we/req_addr/req_wd        request payload, addr = {select, local addr}
//   rsp_valid/rsp_ready           response channel
//   rsp_rd/rsp_err                read data (0 for writes/errors), bad select
//   sdp_we/sdp_re                 one-hot strobes, one bit per peripheral
//   sdp_wa/sdp_ra/sdp_wd          shared address/data to the peripherals
//   sdp_rd                        concatenated peripheral read data
module sdp_host #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 1,
  parameter int N_PERIPH = 4,
  parameter int SEL_W    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [SEL_W+ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]            req_wd,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rd,
  output logic                         rsp_err,
  output logic [N_PERIPH-1:0]          sdp_we,
  output logic [ADDR_W-1:0]            sdp_wa,
  output logic [DATA_W-1:0]            sdp_wd,
  output logic [N_PERIPH-1:0]          sdp_re,
  output logic [ADDR_W-1:0]            sdp_ra,
  input  logic [N_PERIPH*DATA_W-1:0]   sdp_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                req_fire;
  logic [SEL_W-1:0]    req_sel;
  logic                lat_we;
  logic                lat_err;
  logic [SEL_W-1:0]    lat_sel;
  logic [N_PERIPH-1:0] sel_onehot;
  logic [DATA_W-1:0]   rd_slice;

  assign req_sel  = req_addr[SEL_W+ADDR_W-1:ADDR_W];
  assign req_fire = req_valid && req_ready;

  // Decode the latched select into a strobe mask and pick the matching read
  // data slice. An out-of-range select matches nothing, so the mask stays 0.
  always_comb begin
    sel_onehot = '0;
    rd_slice   = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      if (lat_sel == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
        rd_slice      = sdp_rd[k*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_fire) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (lat_we || lat_err) ? S_RESP : S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. The strobes and rsp_valid depend only on the
  // state register, so they drop as soon as reset asserts. req_ready is also
  // gated by rst_n so that it reads 0 while reset is held.
  always_comb begin
    req_ready = (state == S_IDLE) && rst_n;
    rsp_valid = (state == S_RESP);
    sdp_we    = '0;
    sdp_re    = '0;
    if (state == S_ISSUE && !lat_err) begin
      if (lat_we) sdp_we = sel_onehot;
      else        sdp_re = sel_onehot;
    end
  end

  // Request latch. The shared address/data buses come straight from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we  <= 1'b0;
      lat_err <= 1'b0;
      lat_sel <= '0;
      sdp_wa  <= '0;
      sdp_ra  <= '0;
      sdp_wd  <= '0;
    end else if (req_fire) begin
      lat_we  <= req_we;
      lat_err <= ({1'b0, req_sel} >= (SEL_W+1)'(N_PERIPH));
      lat_sel <= req_sel;
      sdp_wa  <= req_addr[ADDR_W-1:0];
      sdp_ra  <= req_addr[ADDR_W-1:0];
      sdp_wd  <= req_wd;
    end
  end

  // Response payload. It is only written on the way into RESP, so it holds
  // steady while the consumer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rd  <= '0;
      rsp_err <= 1'b0;
    end else if (state == S_ISSUE && (lat_we || lat_err)) begin
      rsp_rd  <= '0;
      rsp_err <= lat_err;
    end else if (state == S_WAIT) begin
      rsp_rd  <= rd_slice;
      rsp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdp_host.sv
// Self-checking bench for sdp_host: directed scenarios, then a random mix
// checked against a per-peripheral register-array scoreboard.
module tb_sdp_host;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 1;
  localparam int N_PERIPH = 4;
  localparam int SEL_W    = 3;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       req_valid, req_ready, req_we;
  logic [SEL_W+ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]          req_wd;
  logic                       rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0]          rsp_rd;
  logic [N_PERIPH-1:0]        sdp_we, sdp_re;
  logic [ADDR_W-1:0]          sdp_wa, sdp_ra;
  logic [DATA_W-1:0]          sdp_wd;
  logic [N_PERIPH*DATA_W-1:0] sdp_rd;

  sdp_host #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_PERIPH(N_PERIPH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .sdp_we(sdp_we), .sdp_wa(sdp_wa), .sdp_wd(sdp_wd),
    .sdp_re(sdp_re), .sdp_ra(sdp_ra), .sdp_rd(sdp_rd)
  );

  always #5 clk = ~clk;

  // GPIO-like peripherals: two registers each, read data registered on re.
  logic [DATA_W-1:0] pmem [N_PERIPH][2];
  logic [DATA_W-1:0] prd  [N_PERIPH];
  initial begin
    for (int k = 0; k < N_PERIPH; k++) begin
      prd[k] = '0; pmem[k][0] = '0; pmem[k][1] = '0;
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < N_PERIPH; k++) begin
      if (sdp_we[k]) pmem[k][sdp_wa] <= sdp_wd;
      if (sdp_re[k]) prd[k] <= pmem[k][sdp_ra];
    end
  end
  assign sdp_rd = {prd[3], prd[2], prd[1], prd[0]};

  // Scoreboard: expected register contents of every peripheral.
  logic [DATA_W-1:0] ref_mem [N_PERIPH][2];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0, strobe_cnt = 0, shape_bad = 0;
  int exp_acc = 0, exp_strb = 0;

  // Handshakes and strobes observed mid-cycle, where inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) hs_cnt++;
      if ((sdp_we != '0) || (sdp_re != '0)) begin
        strobe_cnt++;
        if (!$onehot({sdp_we, sdp_re})) shape_bad++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with exact cycle-by-cycle timing checks.
  task automatic do_txn(input logic we, input logic [SEL_W+ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input int hold);
    logic [SEL_W-1:0]    sel;
    logic [ADDR_W-1:0]   la;
    logic                err;
    logic [DATA_W-1:0]   exp_rd;
    logic [N_PERIPH-1:0] exp_s;
    int bound;
    sel = addr[SEL_W+ADDR_W-1:ADDR_W];
    la  = addr[ADDR_W-1:0];
    err = (int'(sel) >= N_PERIPH);
    exp_rd = '0;
    exp_s  = '0;
    if (!err) begin
      exp_s = N_PERIPH'(1) << sel;
      if (!we) exp_rd = ref_mem[sel][la];
      else     ref_mem[sel][la] = wd;
    end
    bound = 0;
    while (!req_ready && bound < 20) begin cyc(); bound++; end
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd;
    cyc();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 4'($urandom); req_wd = $urandom;
    exp_acc++;
    if (!err) exp_strb++;
    // T+1: strobe cycle
    check("we_t1", sdp_we, we ? exp_s : '0);
    check("re_t1", sdp_re, we ? '0 : exp_s);
    check("wa_t1", sdp_wa, la);
    check("ra_t1", sdp_ra, la);
    check("wd_t1", sdp_wd, wd);
    check("vld_t1", rsp_valid, 0);
    check("rdy_t1", req_ready, 0);
    cyc();
    // T+2
    check("we_t2", sdp_we, 0);
    check("re_t2", sdp_re, 0);
    if (!we && !err) begin
      check("vld_t2_read", rsp_valid, 0);
      cyc();
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rd", rsp_rd, exp_rd);
    check("rsp_err", rsp_err, err);
    for (int i = 0; i < hold; i++) begin
      cyc();
      check("hold_vld", rsp_valid, 1);
      check("hold_rd", rsp_rd, exp_rd);
      check("hold_err", rsp_err, err);
      check("hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("vld_after", rsp_valid, 0);
    check("rdy_after", req_ready, 1);
  endtask

  initial begin
    logic [DATA_W-1:0] wd2;
    int hs0;
    for (int k = 0; k < N_PERIPH; k++) begin ref_mem[k][0] = '0; ref_mem[k][1] = '0; end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0; rsp_ready = 1'b0;

    // Reset values
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rd", rsp_rd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_strobes", {sdp_we, sdp_re}, 0);
    check("rst_bus", {sdp_wa, sdp_ra, sdp_wd}, 0);
    #3 rst_n = 1'b1;
    #1 check("ready_after_rst", req_ready, 1);
    cyc();

    // Directed write, read, error read
    do_txn(1'b1, {3'd1, 1'b1}, 32'hA5A5_0001, 0);
    do_txn(1'b1, {3'd2, 1'b0}, 32'h1234_5678, 0);
    do_txn(1'b0, {3'd2, 1'b0}, 32'h0, 0);
    do_txn(1'b0, {3'd5, 1'b0}, 32'h0, 0);
    do_txn(1'b1, {3'd7, 1'b1}, 32'hDEAD_BEEF, 2);
    do_txn(1'b0, {3'd1, 1'b1}, 32'h0, 1);

    // Read under back-pressure with a write waiting behind it
    wd2 = 32'h0BAD_F00D;
    req_valid = 1'b1; req_we = 1'b0; req_addr = {3'd2, 1'b0}; req_wd = '0;
    hs0 = hs_cnt;
    cyc();
    exp_acc++; exp_strb++;
    req_we = 1'b1; req_addr = {3'd3, 1'b1}; req_wd = wd2;
    check("bp_re_t1", sdp_re, 4'b0100);
    check("bp_rdy_t1", req_ready, 0);
    cyc();
    check("bp_rdy_t2", req_ready, 0);
    check("bp_vld_t2", rsp_valid, 0);
    cyc();
    check("bp_vld_t3", rsp_valid, 1);
    check("bp_rd_t3", rsp_rd, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_hold_rd", rsp_rd, 32'h1234_5678);
      check("bp_hold_vld", rsp_valid, 1);
      check("bp_hold_rdy", req_ready, 0);
    end
    check("bp_no_extra_accept", hs_cnt - hs0, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("bp_idle_rdy", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    exp_acc++; exp_strb++;
    ref_mem[3][1] = wd2;
    check("bp_write_strobe", sdp_we, 4'b1000);
    check("bp_write_wd", sdp_wd, wd2);
    check("bp_accept_once", hs_cnt - hs0, 2);
    cyc();
    check("bp_write_rsp", {rsp_valid, rsp_err}, 2'b10);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("bp_accept_total", hs_cnt - hs0, 2);
    do_txn(1'b0, {3'd3, 1'b1}, 32'h0, 0);

    // Reset during ISSUE of a write: the transaction is discarded
    req_valid = 1'b1; req_we = 1'b1; req_addr = {3'd0, 1'b0}; req_wd = 32'h5555_AAAA;
    cyc();
    req_valid = 1'b0;
    exp_acc++;
    check("rstmid_we_before", sdp_we, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("rstmid_we_drop", sdp_we, 0);
    check("rstmid_vld", rsp_valid, 0);
    check("rstmid_rdy", req_ready, 0);
    cyc();
    #2 rst_n = 1'b1;
    #1 check("rstmid_rdy_release", req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rstmid_no_rsp", rsp_valid, 0);
      check("rstmid_no_strobe", {sdp_we, sdp_re}, 0);
    end
    do_txn(1'b0, {3'd0, 1'b0}, 32'h0, 0);

    // Random mix
    for (int n = 0; n < 1000; n++) begin
      logic [SEL_W-1:0] s;
      if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(4, 7));
      else                           s = 3'($urandom_range(0, 3));
      repeat ($urandom_range(0, 1)) cyc();
      do_txn(1'($urandom), {s, 1'($urandom)}, $urandom, $urandom_range(0, 2));
    end

    check("accept_count", hs_cnt, exp_acc);
    check("strobe_count", strobe_cnt, exp_strb);
    check("strobe_shape", shape_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
